seg7_scan_display: RTL and testbench

//   Display-side reader for the 32-bit hex entry word: time-multiplexes 8 hex nibbles onto an
//   8-digit common-anode seven-segment display. Value is double-buffered so an update never

---
 rtl/seg7_scan_display.sv | 120 ++++++++++++
 tb/tb_seg7_scan_display.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Eight-digit multiplexed seven-segment driver for a 32-bit hex word.
// The value is double-buffered so a new word only appears at a frame boundary.
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000,
    parameter int GUARD    = 16,
    parameter int BLANK_LZ = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        load,
    input  logic [7:0]  dp_mask,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   pend_val_q, pend_val_d;
    logic          pend_q, pend_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tc;
    logic          boundary;
    logic [3:0]    nib;
    logic [31:0]   upper;
    logic          blank;
    logic          guard;
    logic          lit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tc         = (presc_q == PW'(SCAN_DIV - 1));
    assign boundary   = tc && (idx_q == 3'd7);
    assign frame_done = boundary;

    always_comb begin
        presc_d    = tc ? '0 : presc_q + 1'b1;
        idx_d      = tc ? idx_q + 3'd1 : idx_q;
        shadow_d   = shadow_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        // A load landing on the boundary itself bypasses the pending buffer.
        if (boundary) begin
            pend_d = 1'b0;
            if (load) begin
                shadow_d = din;
            end else if (pend_q) begin
                shadow_d = pend_val_q;
            end
        end else if (load) begin
            pend_val_d = din;
            pend_d     = 1'b1;
        end
    end

    always_comb begin
        nib   = shadow_q[{idx_q, 2'b00} +: 4];
        upper = shadow_q >> {idx_q, 2'b00};
        blank = (BLANK_LZ != 0) && (idx_q != 3'd0) && (upper == 32'd0);
        guard = (presc_q < PW'(GUARD));
        lit   = !guard && !blank;
        an_d  = lit ? ~(8'b1 << idx_q) : 8'hFF;
        seg_d = lit ? hex7(nib) : 7'h7F;
        dp_d  = lit ? ~dp_mask[idx_q] : 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= 3'd0;
            shadow_q   <= 32'd0;
            pend_val_q <= 32'd0;
            pend_q     <= 1'b0;
            an_q       <= 8'hFF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display with SCAN_DIV=4, GUARD=1; a second
// instance with leading-zero blanking disabled shares all inputs.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        load;
    logic [7:0]  dp_mask;
    logic [7:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;
    logic        dp, dp_nb;
    logic        frame_done, frame_done_nb;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc;

    always #5 clk = ~clk;

    seg7_scan_display #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .din(din), .load(load), .dp_mask(dp_mask),
        .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
    );

    seg7_scan_display #(.SCAN_DIV(4), .GUARD(1), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .din(din), .load(load), .dp_mask(dp_mask),
        .an(an_nb), .seg(seg_nb), .dp(dp_nb), .frame_done(frame_done_nb)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge; drives one load strobe and returns on the next negedge.
    task automatic do_load(input logic [31:0] v);
        din  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Counts negedges until frame_done, bounded so a dead scan cannot hang the run.
    task automatic count_to_fd(output int n);
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Waits for a frame boundary (N0), then checks each slot: guard cycle at
    // N(4d+2) and first lit cycle at N(4d+3). Returns at N31 of that frame.
    task automatic check_frame(input string tag, input logic [55:0] exp_seg,
                               input logic [7:0] exp_lit, input bit nb);
        int n;
        logic [7:0] a;
        logic [6:0] s;
        logic       p;
        count_to_fd(n);
        chk({tag, " fd"}, {31'd0, frame_done}, 32'd1);
        @(negedge clk);
        for (int d = 0; d < 8; d++) begin
            @(negedge clk);
            a = nb ? an_nb : an;
            chk($sformatf("%s d%0d guard_an", tag, d), {24'd0, a}, 32'hFF);
            @(negedge clk);
            a = nb ? an_nb : an;
            s = nb ? seg_nb : seg;
            p = nb ? dp_nb : dp;
            if (exp_lit[d]) begin
                chk($sformatf("%s d%0d an", tag, d), {24'd0, a}, {24'd0, ~(8'b1 << d)});
                chk($sformatf("%s d%0d seg", tag, d), {25'd0, s}, {25'd0, exp_seg[7*d +: 7]});
                chk($sformatf("%s d%0d dp", tag, d), {31'd0, p}, {31'd0, ~dp_mask[d]});
            end else begin
                chk($sformatf("%s d%0d an", tag, d), {24'd0, a}, 32'hFF);
                chk($sformatf("%s d%0d seg", tag, d), {25'd0, s}, 32'h7F);
                chk($sformatf("%s d%0d dp", tag, d), {31'd0, p}, 32'd1);
            end
            if (d < 7) repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        din     = 32'd0;
        load    = 1'b0;
        dp_mask = 8'h05;
        #3;
        chk("rst an", {24'd0, an}, 32'hFF);
        chk("rst seg", {25'd0, seg}, 32'h7F);
        chk("rst dp", {31'd0, dp}, 32'd1);
        chk("rst fd", {31'd0, frame_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        // Scan starts at (digit 0, count 0); terminal count of digit 7 is 31 cycles on.
        count_to_fd(n_cyc);
        chk("first_fd_cycles", n_cyc, 32'd31);

        // Zero value: only digit 0 lit; digit 2 stays dark despite its dp bit.
        check_frame("zero", {{7{7'h7F}}, 7'h40}, 8'h01, 1'b0);
        check_frame("zero_nb", {8{7'h40}}, 8'hFF, 1'b1);

        dp_mask = 8'h01;
        do_load(32'h89ABCDEF);
        check_frame("full", {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E},
                    8'hFF, 1'b0);

        // Two loads mid-frame: the running frame keeps showing 89ABCDEF.
        count_to_fd(n_cyc);
        repeat (5) @(negedge clk);
        do_load(32'h11111111);
        do_load(32'h22222222);
        repeat (24) @(negedge clk);
        chk("tear d7 an", {24'd0, an}, 32'h7F);
        chk("tear d7 seg", {25'd0, seg}, 32'h00);
        check_frame("newest", {8{7'h24}}, 8'hFF, 1'b0);

        do_load(32'h000000A5);
        check_frame("lz", {{6{7'h7F}}, 7'h08, 7'h12}, 8'h03, 1'b0);

        // Load coinciding with frame_done goes straight to the display.
        count_to_fd(n_cyc);
        chk("coll fd", {31'd0, frame_done}, 32'd1);
        do_load(32'h00000007);
        @(negedge clk);
        chk("coll guard an", {24'd0, an}, 32'hFF);
        @(negedge clk);
        chk("coll d0 an", {24'd0, an}, 32'hFE);
        chk("coll d0 seg", {25'd0, seg}, 32'h78);
        check_frame("coll_next", {{7{7'h7F}}, 7'h78}, 8'h01, 1'b0);

        // Reset while digit 0 is lit: outputs go dark immediately, scan restarts.
        repeat (4) @(negedge clk);
        chk("pre_rst lit an", {24'd0, an}, 32'hFE);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst an", {24'd0, an}, 32'hFF);
        chk("mid_rst seg", {25'd0, seg}, 32'h7F);
        chk("mid_rst dp", {31'd0, dp}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        count_to_fd(n_cyc);
        chk("rst_fd_cycles", n_cyc, 32'd31);
        check_frame("after_rst", {{7{7'h7F}}, 7'h40}, 8'h01, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
